// File: rtl/adc_sample_sequencer.sv
// Paces the SPI ADC controller at a fixed sample rate, converts offset-binary samples to signed,
// applies a power-of-two moving average and queues the results in a valid/ready FIFO.
module adc_sample_sequencer #(
    parameter int CLK_DIV        = 5000,
    parameter int AVG_LOG2       = 2,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic       clock_50Mhz,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       clear_errors,
    input  logic       adc_sampleReady,
    input  logic [7:0] adc_outputSample,
    output logic       adc_sendSample,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_timeout,
    output logic       err_overflow,
    output logic       err_overrun
);

    localparam int DATA_W = 8;
    localparam int SUM_W  = DATA_W + AVG_LOG2;
    localparam int AVG_N  = 1 << AVG_LOG2;
    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, CAPTURE, PROC} state_t;

    function automatic logic signed [DATA_W-1:0] offset_to_signed(input logic [DATA_W-1:0] raw);
        return signed'({~raw[DATA_W-1], raw[DATA_W-2:0]});
    endfunction

    function automatic logic signed [SUM_W-1:0] sext(input logic signed [DATA_W-1:0] v);
        return SUM_W'(v);
    endfunction

    // Arithmetic shift floors toward -inf; the window mean always fits back into DATA_W bits.
    function automatic logic signed [DATA_W-1:0] floor_avg(input logic signed [SUM_W-1:0] v);
        return DATA_W'(v >>> AVG_LOG2);
    endfunction

    state_t                    state, state_next;
    logic                      sync_meta, sync_q, sync_prev, ready_rise;
    logic [CNT_W-1:0]          tick_cnt;
    logic                      tick;
    logic [TO_W-1:0]           to_cnt;
    logic                      timeout_hit, overrun_hit, overflow_hit;
    logic                      vld_p0, vld_p1;
    logic signed [DATA_W-1:0]  s_p0;
    logic signed [DATA_W-1:0]  hist [AVG_N];
    logic signed [SUM_W-1:0]   sum, sum_next_p1;
    logic signed [DATA_W-1:0]  avg_p1;
    logic [DATA_W-1:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [PTR_W:0]            count;
    logic                      full, pop, do_push;

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_meta <= adc_sampleReady;
            sync_q    <= sync_meta;
            sync_prev <= sync_q;
        end
    end

    assign ready_rise = sync_q & ~sync_prev;

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n)                 tick_cnt <= '0;
        else if (!enable)             tick_cnt <= '0;
        else if (tick_cnt == CNT_MAX) tick_cnt <= '0;
        else                          tick_cnt <= tick_cnt + CNT_W'(1);
    end

    assign tick = enable && (tick_cnt == CNT_MAX);

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE:    if (tick) state_next = REQ;
            REQ: begin
                if (ready_rise) begin
                    state_next = CAPTURE;
                end else if (to_cnt == TO_MAX) begin
                    state_next  = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            CAPTURE: state_next = PROC;
            PROC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        adc_sendSample = 1'b0;
        vld_p0         = 1'b0;
        vld_p1         = 1'b0;
        case (state)
            REQ:     adc_sendSample = 1'b1;
            CAPTURE: vld_p0 = 1'b1;
            PROC:    vld_p1 = 1'b1;
            default: ;
        endcase
    end

    assign overrun_hit = tick && (state != IDLE);

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n)                    to_cnt <= '0;
        else if (state == IDLE && tick)  to_cnt <= '0;
        else if (state == REQ)           to_cnt <= to_cnt + TO_W'(1);
    end

    // p0: capture the converted sample
    always_ff @(posedge clock_50Mhz) begin
        if (vld_p0) s_p0 <= offset_to_signed(adc_outputSample);
    end

    // p1: running-sum update, history shift and FIFO push
    assign sum_next_p1 = sum + sext(s_p0) - sext(hist[AVG_N-1]);
    assign avg_p1      = floor_avg(sum_next_p1);

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            sum <= '0;
            for (int i = 0; i < AVG_N; i++) hist[i] <= '0;
        end else if (vld_p1) begin
            sum     <= sum_next_p1;
            hist[0] <= s_p0;
            for (int i = 1; i < AVG_N; i++) hist[i] <= hist[i-1];
        end
    end

    assign full         = (count == FULL_CNT);
    assign out_valid    = (count != '0);
    assign out_data     = mem[rd_ptr];
    assign pop          = out_valid && out_ready;
    assign do_push      = vld_p1 && (!full || pop);
    assign overflow_hit = vld_p1 && full && !pop;

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= avg_p1;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !pop)      count <= count + (PTR_W + 1)'(1);
            else if (!do_push && pop) count <= count - (PTR_W + 1)'(1);
        end
    end

    // A new event in the same cycle as clear_errors keeps its flag set.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            err_timeout  <= timeout_hit  | (err_timeout  & ~clear_errors);
            err_overflow <= overflow_hit | (err_overflow & ~clear_errors);
            err_overrun  <= overrun_hit  | (err_overrun  & ~clear_errors);
        end
    end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer: two instances (averaging off and 4-sample average)
// driven by simple ADC responder models, with a scoreboard of expected FIFO outputs.
module tb_adc_sample_sequencer;

    localparam int CLK_DIV  = 300;
    localparam int TIMEOUT  = 2000;
    localparam int DEPTH    = 8;
    localparam int CLK_DIV0 = 100;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       reset_n, clear_errors;
    logic       enable, adc_ready, out_ready;
    logic [7:0] adc_data;
    logic       send, out_valid, err_timeout, err_overflow, err_overrun;
    logic [7:0] out_data;

    logic       enable0, ready0, out_ready0;
    logic [7:0] data0;
    logic       send0, out_valid0, err_timeout0, err_overflow0, err_overrun0;
    logic [7:0] out_data0;

    adc_sample_sequencer #(
        .CLK_DIV(CLK_DIV), .AVG_LOG2(2), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock_50Mhz(clk), .reset_n(reset_n), .enable(enable), .clear_errors(clear_errors),
        .adc_sampleReady(adc_ready), .adc_outputSample(adc_data), .adc_sendSample(send),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .err_timeout(err_timeout), .err_overflow(err_overflow), .err_overrun(err_overrun)
    );

    adc_sample_sequencer #(
        .CLK_DIV(CLK_DIV0), .AVG_LOG2(0), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(50)
    ) dut0 (
        .clock_50Mhz(clk), .reset_n(reset_n), .enable(enable0), .clear_errors(clear_errors),
        .adc_sampleReady(ready0), .adc_outputSample(data0), .adc_sendSample(send0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
        .err_timeout(err_timeout0), .err_overflow(err_overflow0), .err_overrun(err_overrun0)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_q0[$];
    logic [7:0] stim[$];
    logic [7:0] stim0[$];
    int         win[4];
    int         n_resp     = 0;
    int         adc_delay  = 5;
    bit         adc_silent = 1'b0;
    logic [7:0] adc_val    = 8'h80;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
    endtask

    // Reference: floor of the mean of the last four signed samples, window starting at zero.
    task automatic model_push(input logic [7:0] raw);
        int sum;
        for (int i = 3; i > 0; i--) win[i] = win[i-1];
        win[0] = int'(raw) - 128;
        sum = win[0] + win[1] + win[2] + win[3];
        if (exp_q.size() < DEPTH) exp_q.push_back(8'(sum >>> 2));
    endtask

    always begin
        @(posedge send);
        if (!adc_silent) begin
            repeat (adc_delay) @(posedge clk);
            #2;
            if (stim.size() > 0) adc_data = stim.pop_front();
            else                 adc_data = adc_val;
            model_push(adc_data);
            adc_ready = 1'b1;
            n_resp++;
            repeat (6) @(posedge clk);
            #2 adc_ready = 1'b0;
        end
    end

    always begin
        @(posedge send0);
        repeat (5) @(posedge clk);
        #2;
        if (stim0.size() > 0) data0 = stim0.pop_front();
        else                  data0 = 8'h80;
        exp_q0.push_back(8'(int'(data0) - 128));
        ready0 = 1'b1;
        repeat (6) @(posedge clk);
        #2 ready0 = 1'b0;
    end

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            check("out_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
        end
        if (reset_n && out_valid0 && out_ready0) begin
            check("out0_expected", 32'(exp_q0.size() != 0), 1);
            if (exp_q0.size() != 0) check("out0_data", out_data0, exp_q0.pop_front());
        end
    end

    function automatic logic sig(input int sel);
        return (sel == 0) ? send0 : send;
    endfunction

    task automatic wait_rise(input int sel, input int limit, output int cycles);
        logic prev;
        cycles = -1;
        prev   = sig(sel);
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (!prev && sig(sel)) begin
                cycles = i;
                return;
            end
            prev = sig(sel);
        end
    endtask

    task automatic wait_resp(input int target, input int limit);
        for (int i = 0; i < limit && n_resp < target; i++) @(posedge clk);
        #1 check("resp_count", n_resp, target);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && stim.size() == 0 && !send && !adc_ready) break;
        end
        repeat (4) @(posedge clk);
        #1;
        check("drain_queue", exp_q.size(), 0);
        check("drain_valid", out_valid, 0);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #2 clear_errors = 1'b1;
        @(posedge clk); #2 clear_errors = 1'b0;
    endtask

    int c, hc, base;

    initial begin
        reset_n = 1'b0; clear_errors = 1'b0;
        enable = 1'b0; adc_ready = 1'b0; adc_data = 8'h00; out_ready = 1'b1;
        enable0 = 1'b0; ready0 = 1'b0; data0 = 8'h00; out_ready0 = 1'b1;
        for (int i = 0; i < 4; i++) win[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_send", send, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_timeout", err_timeout, 0);
        check("rst_overflow", err_overflow, 0);
        check("rst_overrun", err_overrun, 0);
        check("rst_send0", send0, 0);
        check("rst_valid0", out_valid0, 0);
        @(posedge clk); #2 reset_n = 1'b1;

        // No averaging: C8 -> 48, 00 -> 80, 80 -> 00; tick period CLK_DIV0
        stim0 = '{8'hC8, 8'h00, 8'h80};
        enable0 = 1'b1;
        wait_rise(0, 300, c);
        check("dut0_first_tick", c, CLK_DIV0);
        wait_rise(0, 300, c);
        check("dut0_tick_period", c, CLK_DIV0);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (stim0.size() == 0 && exp_q0.size() == 0 && !send0 && !ready0) break;
        end
        enable0 = 1'b0;
        check("dut0_drained", exp_q0.size(), 0);

        // Averaging ramp: FF x8 then 7F x4
        for (int i = 0; i < 8; i++) stim.push_back(8'hFF);
        for (int i = 0; i < 4; i++) stim.push_back(8'h7F);
        enable = 1'b1;
        for (int i = 0; i < 13 * CLK_DIV && stim.size() != 0; i++) @(posedge clk);
        #1 enable = 1'b0;
        drain(2000);

        // Silent ADC: request held TIMEOUT cycles, no push, then retry
        adc_silent = 1'b1;
        enable = 1'b1;
        wait_rise(1, 400, c);
        check("to_req_seen", 32'(c > 0), 1);
        hc = 1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (send) hc++;
            else break;
        end
        check("to_req_len", hc, TIMEOUT);
        check("to_flag", err_timeout, 1);
        check("to_no_push", out_valid, 0);
        check("to_overrun", err_overrun, 1);
        pulse_clear();
        #1;
        check("clr_timeout", err_timeout, 0);
        check("clr_overrun", err_overrun, 0);
        adc_silent = 1'b0;
        adc_val = 8'h80;
        base = n_resp;
        wait_resp(base + 1, 600);
        enable = 1'b0;
        drain(200);
        check("retry_timeout", err_timeout, 0);

        // Overflow: 10 samples into an 8-deep FIFO with the consumer stalled
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) stim.push_back(8'(8'h10 + k * 8));
        base = n_resp;
        enable = 1'b1;
        wait_resp(base + 8, 9 * CLK_DIV);
        repeat (10) @(posedge clk);
        #1;
        check("ovf_before", err_overflow, 0);
        check("ovf_valid", out_valid, 1);
        wait_resp(base + 9, 2 * CLK_DIV);
        repeat (10) @(posedge clk);
        #1 check("ovf_after9", err_overflow, 1);
        wait_resp(base + 10, 2 * CLK_DIV);
        enable = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("ovf_held", out_valid, 1);
        out_ready = 1'b1;
        drain(200);
        pulse_clear();

        // Overrun: ADC answers after more than one tick period
        adc_delay = 400;
        base = n_resp;
        enable = 1'b1;
        wait_resp(base + 1, 4 * CLK_DIV);
        enable = 1'b0;
        drain(200);
        check("orun_flag", err_overrun, 1);
        check("orun_timeout", err_timeout, 0);
        adc_delay = 5;
        pulse_clear();

        // Reset while a request is outstanding
        out_ready = 1'b0;
        base = n_resp;
        enable = 1'b1;
        wait_resp(base + 1, 2 * CLK_DIV);
        adc_silent = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("pre_rst_valid", out_valid, 1);
        wait_rise(1, 400, c);
        check("pre_rst_req", 32'(c > 0), 1);
        repeat (350) @(posedge clk);
        #1;
        check("pre_rst_send", send, 1);
        check("pre_rst_overrun", err_overrun, 1);
        @(posedge clk); #5 reset_n = 1'b0;
        #1;
        check("arst_send", send, 0);
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_overrun", err_overrun, 0);
        check("arst_timeout", err_timeout, 0);
        check("arst_overflow", err_overflow, 0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) win[i] = 0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        adc_silent = 1'b0;
        adc_val = 8'hC0;
        out_ready = 1'b1;
        c = -1;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk); #1;
            if (send) begin
                c = i;
                break;
            end
        end
        check("post_rst_first_req", c, CLK_DIV);
        base = n_resp;
        wait_resp(base + 1, 100);
        enable = 1'b0;
        drain(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
